// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM states, requester ids, latched transaction
// record and the byte-lane merge used by read-modify-write stores.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        MERGE  = 2'd2,
        RESP   = 2'd3
    } arb_state_e;

    typedef enum logic {
        REQ_C = 1'b0,
        REQ_L = 1'b1
    } req_id_e;

    // The low two address bits are always zero for a granted access, so only the word index is kept.
    typedef struct packed {
        req_id_e     id;
        logic        we;
        logic [29:0] waddr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } txn_t;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  be);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = be[b] ? new_word[8*b +: 8] : old_word[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of the two requester ports (C = CPU load/store unit, L = UART loader) and the
// single-port data-memory port; the arbiter uses the slave view, the environment the master view.
interface dmem_arbiter_if;

    logic        c_req;
    logic        c_we;
    logic [31:0] c_addr;
    logic [31:0] c_wdata;
    logic [3:0]  c_be;
    logic [31:0] c_rdata;
    logic        c_ack;
    logic        c_err;

    logic        l_req;
    logic        l_we;
    logic [31:0] l_addr;
    logic [31:0] l_wdata;
    logic [3:0]  l_be;
    logic [31:0] l_rdata;
    logic        l_ack;
    logic        l_err;

    logic        m_read;
    logic        m_write;
    logic [31:0] m_addr;
    logic [31:0] m_din;
    logic [31:0] m_dout;

    modport slave (
        input  c_req, c_we, c_addr, c_wdata, c_be,
        output c_rdata, c_ack, c_err,
        input  l_req, l_we, l_addr, l_wdata, l_be,
        output l_rdata, l_ack, l_err,
        output m_read, m_write, m_addr, m_din,
        input  m_dout
    );

    modport master (
        output c_req, c_we, c_addr, c_wdata, c_be,
        input  c_rdata, c_ack, c_err,
        output l_req, l_we, l_addr, l_wdata, l_be,
        input  l_rdata, l_ack, l_err,
        input  m_read, m_write, m_addr, m_din,
        output m_dout
    );

endinterface

// File: rtl/dmem_rr_picker.sv
// Two-way round-robin picker: the pointer names the side favoured on contention and moves to
// the opposite side of whichever requester was just served.
module dmem_rr_picker
    import dmem_arb_pkg::*;
#(
    parameter bit RST_PRIO = 1'b0
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic [1:0] req_i,        // bit 0 = C, bit 1 = L
    input  logic     done_i,
    input  req_id_e  done_id_i,
    output logic     grant_valid_o,
    output req_id_e  grant_id_o
);

    req_id_e ptr_q, ptr_d;

    // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        grant_valid_o = |req_i;
        grant_id_o    = ptr_q;
        if (req_i == 2'b01) begin
            grant_id_o = REQ_C;
        end else if (req_i == 2'b10) begin
            grant_id_o = REQ_L;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (done_i) begin
            ptr_d = (done_id_i == REQ_C) ? REQ_L : REQ_C;
        end
    end

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= req_id_e'(RST_PRIO);
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port word memory between the CPU (C) and loader (L).
// Define DMEM_ARB_RMW_EN to enable byte-lane stores via read-modify-write.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W   = 16,
    parameter bit RST_PRIO = 1'b0
) (
    input  logic          clk,
    input  logic          rst_n,
    dmem_arbiter_if.slave bus,
    output logic          busy_o
);

    arb_state_e  state_q, state_d;
    txn_t        txn_q, txn_d;
    logic        err_q, err_d;
    logic [31:0] rdata_c_q, rdata_c_d;
    logic [31:0] rdata_l_q, rdata_l_d;
    logic [31:0] old_q, old_d;

    logic        grant_valid;
    req_id_e     grant_id;
    txn_t        req_txn;
    logic [31:0] req_addr;
    logic        req_bad;
    logic        partial_store;
    logic [31:0] word_addr;

    dmem_rr_picker #(
        .RST_PRIO (RST_PRIO)
    ) u_picker (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_i         ({bus.l_req, bus.c_req}),
        .done_i        (state_q == RESP),
        .done_id_i     (txn_q.id),
        .grant_valid_o (grant_valid),
        .grant_id_o    (grant_id)
    );

    always_comb begin
        req_txn.id    = REQ_C;
        req_txn.we    = bus.c_we;
        req_txn.wdata = bus.c_wdata;
        req_txn.be    = bus.c_be;
        req_addr      = bus.c_addr;
        if (grant_id == REQ_L) begin
            req_txn.id    = REQ_L;
            req_txn.we    = bus.l_we;
            req_txn.wdata = bus.l_wdata;
            req_txn.be    = bus.l_be;
            req_addr      = bus.l_addr;
        end
        req_txn.waddr = req_addr[31:2];
        req_bad       = ((req_addr >> ADDR_W) != 32'd0) || (req_addr[1:0] != 2'b00);
    end

`ifdef DMEM_ARB_RMW_EN
    assign partial_store = txn_q.we && (txn_q.be != 4'hF) && (txn_q.be != 4'h0);
`else
    assign partial_store = 1'b0;
`endif

    assign word_addr = {txn_q.waddr, 2'b00};

    always_comb begin
        state_d     = state_q;
        txn_d       = txn_q;
        err_d       = err_q;
        rdata_c_d   = rdata_c_q;
        rdata_l_d   = rdata_l_q;
        old_d       = old_q;
        bus.m_read  = 1'b0;
        bus.m_write = 1'b0;
        bus.m_addr  = 32'd0;
        bus.m_din   = 32'd0;

        unique case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    txn_d   = req_txn;
                    err_d   = req_bad;
                    state_d = req_bad ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                bus.m_addr = word_addr;
                state_d    = RESP;
                if (!txn_q.we) begin
                    bus.m_read = 1'b1;
                    if (txn_q.id == REQ_C) begin
                        rdata_c_d = bus.m_dout;
                    end else begin
                        rdata_l_d = bus.m_dout;
                    end
                end else if (partial_store) begin
                    bus.m_read = 1'b1;
                    old_d      = bus.m_dout;
                    state_d    = MERGE;
                end else begin
                    // Without RMW any nonzero byte-enable is a full-word write; be == 0 is a no-op store.
                    bus.m_write = (txn_q.be != 4'h0);
                    bus.m_din   = txn_q.wdata;
                end
            end
            MERGE: begin
                bus.m_addr  = word_addr;
                bus.m_write = 1'b1;
                bus.m_din   = merge_bytes(old_q, txn_q.wdata, txn_q.be);
                state_d     = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            err_q     <= 1'b0;
            rdata_c_q <= 32'd0;
            rdata_l_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            err_q     <= err_d;
            rdata_c_q <= rdata_c_d;
            rdata_l_q <= rdata_l_d;
        end
    end

    // NOTE: payload registers need no reset; they are only observed while state_q qualifies them.
    always_ff @(posedge clk) begin
        txn_q <= txn_d;
        old_q <= old_d;
    end

    assign bus.c_ack   = (state_q == RESP) && (txn_q.id == REQ_C);
    assign bus.l_ack   = (state_q == RESP) && (txn_q.id == REQ_L);
    assign bus.c_err   = bus.c_ack && err_q;
    assign bus.l_err   = bus.l_ack && err_q;
    assign bus.c_rdata = rdata_c_q;
    assign bus.l_rdata = rdata_l_q;
    assign busy_o      = (state_q != IDLE);

endmodule
